apb_event_master: RTL

Parametrised N-channel event-to-APB write master. Successor to the fixed three-event APB block.
- Collects single-cycle event pulses per channel into saturating pending counters.
- Arbitrates channels round-robin.
- Issues one APB write per grant, reporting channel index and coalesced event count.
- Sits between event sources (timers, status logic) and the APB interconnect as the only APB requester.

---
 rtl/apb_event_master.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/apb_event_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_event_master                                              |
// | Summary  : N-channel event counter with round-robin APB write master.    |
// |            Optional ACCESS-phase timeout via macro APB_TIMEOUT_EN.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module apb_event_master #(
    parameter int                NUM_EVENTS     = 3,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                ADDR_STRIDE    = 4,
    parameter int                CNT_W          = 8,
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  apb_pready_i,
    output logic                  apb_psel_o,
    output logic                  apb_penable_o,
    output logic [ADDR_W-1:0]     apb_paddr_o,
    output logic                  apb_pwrite_o,
    output logic [DATA_W-1:0]     apb_pwdata_o,
    output logic [NUM_EVENTS-1:0] overflow_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int c_ptr_w = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    if (NUM_EVENTS < 1 || NUM_EVENTS > 256 || DATA_W < CNT_W + 8 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_event_master: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_pend [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] r_ovf;
    logic [c_ptr_w-1:0]    r_ptr;
    logic [ADDR_W-1:0]     r_paddr;
    logic [DATA_W-1:0]     r_pwdata;
    logic                  r_timeout;

    logic [c_ptr_w-1:0]    w_grant;
    logic                  w_any;
    logic                  w_load;
    logic                  w_expire;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     w_wdata;

    // Round-robin search starting just after the last granted channel.
    always_comb begin : p_grant
        int v_idx;
        v_idx   = 0;
        w_grant = '0;
        w_any   = 1'b0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            v_idx = int'(r_ptr) + 1 + i;
            if (v_idx >= NUM_EVENTS) v_idx = v_idx - NUM_EVENTS;
            if (!w_any && (r_pend[v_idx] != '0)) begin
                w_any   = 1'b1;
                w_grant = c_ptr_w'(v_idx);
            end
        end
    end

    always_comb begin
        w_addr  = BASE_ADDR + ADDR_W'(w_grant) * ADDR_W'(ADDR_STRIDE);
        w_wdata = '0;
        w_wdata[DATA_W-1 -: 8] = 8'(w_grant);
        w_wdata[CNT_W-1:0]     = r_pend[w_grant];
    end

`ifdef APB_TIMEOUT_EN
    localparam int c_tc_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_tc_w-1:0] r_tcnt;

    // Expiry fires on the edge closing the last permitted wait cycle.
    assign w_expire = (r_state == S_ACCESS) && !apb_pready_i &&
                      (r_tcnt == c_tc_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if ((r_state == S_ACCESS) && !w_expire) begin
            r_tcnt <= r_tcnt + 1'b1;
        end else begin
            r_tcnt <= '0;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        apb_psel_o    = 1'b0;
        apb_penable_o = 1'b0;
        apb_pwrite_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_SETUP;
                    w_load      = 1'b1;
                end
            end
            S_SETUP: begin
                apb_psel_o   = 1'b1;
                apb_pwrite_o = 1'b1;
                w_state_nxt  = S_ACCESS;
            end
            S_ACCESS: begin
                apb_psel_o    = 1'b1;
                apb_penable_o = 1'b1;
                apb_pwrite_o  = 1'b1;
                if (apb_pready_i || w_expire) begin
                    if (w_any) begin
                        w_state_nxt = S_SETUP;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= w_expire;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= c_ptr_w'(NUM_EVENTS - 1);
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_load) begin
            r_ptr    <= w_grant;
            r_paddr  <= w_addr;
            r_pwdata <= w_wdata;
        end
    end

    // The granted counter restarts from this cycle's event so none is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NUM_EVENTS; n++) r_pend[n] <= '0;
            r_ovf <= '0;
        end else begin
            for (int n = 0; n < NUM_EVENTS; n++) begin
                if (w_load && (w_grant == c_ptr_w'(n))) begin
                    r_pend[n] <= event_i[n] ? c_cnt_one : '0;
                end else if (event_i[n]) begin
                    if (r_pend[n] == c_cnt_max) begin
                        r_ovf[n] <= 1'b1;
                    end else begin
                        r_pend[n] <= r_pend[n] + 1'b1;
                    end
                end
            end
        end
    end

    assign apb_paddr_o  = r_paddr;
    assign apb_pwdata_o = r_pwdata;
    assign overflow_o   = r_ovf;
    assign busy_o       = (r_state != S_IDLE) || w_any;
    assign timeout_o    = r_timeout;

endmodule
`default_nettype wire
